// File: rtl/wr_merge_arb.sv
`default_nettype none
// ============================================================================
// Module      : wr_merge_arb
// Description : Two-to-one write merger. Each source feeds a small FIFO; a
//               round-robin arbiter drains both FIFOs into one registered
//               valid/ready output channel tagged with the source index.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_merge_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S1_valid,
    input  logic [ADDR_W-1:0] S1_addr,
    input  logic [DATA_W-1:0] S1_data,
    output logic              S1_ready,
    input  logic              S2_valid,
    input  logic [ADDR_W-1:0] S2_addr,
    input  logic [DATA_W-1:0] S2_data,
    output logic              S2_ready,
    output logic              M_valid,
    output logic [ADDR_W-1:0] M_addr,
    output logic [DATA_W-1:0] M_data,
    output logic              M_src,
    input  logic              M_ready
);

    localparam int                 c_PTR_W  = $clog2(DEPTH);
    localparam int                 c_CNT_W  = c_PTR_W + 1;
    localparam int                 c_WORD_W = ADDR_W + DATA_W;
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_WR_DATA = 1'b1;

    // Per-source storage; index 0 is S1, index 1 is S2.
    logic [c_WORD_W-1:0] r_mem  [2][DEPTH];
    logic [c_PTR_W-1:0]  r_wptr [2];
    logic [c_PTR_W-1:0]  r_rptr [2];
    logic [c_CNT_W-1:0]  r_cnt  [2];

    logic [0:0]          r_state;
    logic                r_last_grant;

    logic [1:0]          w_in_valid;
    logic [c_WORD_W-1:0] w_in_word [2];
    logic [1:0]          w_ready;
    logic [1:0]          w_ne;
    logic [1:0]          w_push;
    logic [1:0]          w_pop;
    logic                w_any;
    logic                w_grant;
    logic                w_load;
    logic [c_WORD_W-1:0] w_head;

    assign w_in_valid   = {S2_valid, S1_valid};
    assign w_in_word[0] = {S1_addr, S1_data};
    assign w_in_word[1] = {S2_addr, S2_data};

    // Ready depends only on the registered count, so a pop never frees a slot
    // combinationally; the freed slot becomes visible on the following cycle.
    assign S1_ready = w_ready[0];
    assign S2_ready = w_ready[1];

    // Emptiness/fullness, grant selection and the output-register load enable.
    always_comb begin
        w_ready = 2'b00;
        w_ne    = 2'b00;
        w_push  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_ready[i] = (r_cnt[i] != c_FULL);
            w_ne[i]    = (r_cnt[i] != '0);
            w_push[i]  = w_in_valid[i] && w_ready[i];
        end
        w_any = |w_ne;
        // Both pending: alternate against the last winner; otherwise the only
        // non-empty source wins.
        if (&w_ne) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = ~w_ne[0];
        end
        // The output register is free when idle or when its beat is taken now.
        w_load = w_any && ((r_state == c_IDLE) || M_ready);
        w_pop  = w_load ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
        w_head = r_mem[w_grant][r_rptr[w_grant]];
    end

    // FIFO storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= w_in_word[i];
            end
        end
    end

    // FIFO pointers and occupancy; push and pop on one edge cancel in count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + c_PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + c_PTR_W'(1);
                end
                r_cnt[i] <= r_cnt[i] + c_CNT_W'(w_push[i]) - c_CNT_W'(w_pop[i]);
            end
        end
    end

    // Output FSM: loads the granted head into the output register, holds it
    // under backpressure and reloads back-to-back on a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            M_valid      <= 1'b0;
            M_addr       <= '0;
            M_data       <= '0;
            M_src        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_load) begin
                        {M_addr, M_data} <= w_head;
                        M_src        <= w_grant;
                        M_valid      <= 1'b1;
                        r_last_grant <= w_grant;
                        r_state      <= c_WR_DATA;
                    end
                end
                c_WR_DATA: begin
                    if (M_ready) begin
                        if (w_load) begin
                            {M_addr, M_data} <= w_head;
                            M_src        <= w_grant;
                            r_last_grant <= w_grant;
                        end else begin
                            M_valid <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    M_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
